// File: rtl/cheat_pgm_ctrl.sv
// cheat_pgm_ctrl: buffers MCU cheat-table commands and replays them into the
// cheat block's programming port (pgm_idx/pgm_we/pgm_in). A write is raised
// only inside a short window after SNES_cycle_start, or at any time once the
// SNES has been idle long enough to saturate the idle counter.
// Build option: define CHEAT_PGM_ATOMIC_EN to wrap entry writes in a
// mask-off / write / mask-on sequence driven from the enable-mask shadow.
module cheat_pgm_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GUARD      = 3,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SNES_cycle_start,
  input  logic        pgm_blocked,
  input  logic        mcu_valid,
  output logic        mcu_ready,
  input  logic [2:0]  mcu_slot,
  input  logic [31:0] mcu_data,
  input  logic        mcu_en,
  output logic [2:0]  pgm_idx,
  output logic        pgm_we,
  output logic [31:0] pgm_in,
  output logic [5:0]  mask_shadow,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 36;

  typedef enum logic [2:0] {
    IDLE,
    MASK_OFF,
    ENTRY,
    MASK_ON,
    SINGLE
  } state_t;

  state_t state_q, state_d;

  // FIFO entry layout: {slot[2:0], data[31:0], en}
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] head;

  logic [3:0]           win_cnt;
  logic [TIMEOUT_W-1:0] idle_cnt;
  logic                 win_open;
  logic                 commit;

  logic [2:0]  cur_slot_q, cur_slot_d;
  logic [31:0] cur_data_q, cur_data_d;
  logic        cur_en_q, cur_en_d;

  logic        we_d;
  logic [2:0]  idx_d;
  logic [31:0] in_d;
  logic [5:0]  shadow_d;
  logic [2:0]  wr_idx;
  logic [31:0] wr_val;
  logic        busy_d;
  logic        ready_d;

`ifdef CHEAT_PGM_ATOMIC_EN
  logic [5:0] head_bit;
  logic [5:0] cur_bit;
  assign head_bit = 6'b000001 << head[35:33];
  assign cur_bit  = 6'b000001 << cur_slot_q;
`else
  logic unused_en;
  assign unused_en = cur_en_q;
`endif

  assign push     = mcu_valid & mcu_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign head     = fifo_mem[rd_ptr];
  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign win_open = (win_cnt != 4'd0) || (&idle_cnt);
  assign commit   = pgm_we & ~pgm_blocked;

  // FIFO storage; contents are don't-care once the pointers are flushed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {mcu_slot, mcu_data, mcu_en};
  end

  // Safe-window countdown and SNES idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= 4'd0;
      idle_cnt <= '0;
    end else if (SNES_cycle_start) begin
      win_cnt  <= 4'(GUARD);
      idle_cnt <= '0;
    end else begin
      if (win_cnt != 4'd0) win_cnt <= win_cnt - 4'd1;
      if (!(&idle_cnt))    idle_cnt <= idle_cnt + TIMEOUT_W'(1);
    end
  end

  // Next-state, write payload and shadow update
  always_comb begin
    state_d    = state_q;
    cur_slot_d = cur_slot_q;
    cur_data_d = cur_data_q;
    cur_en_d   = cur_en_q;
    shadow_d   = mask_shadow;
    wr_idx     = cur_slot_q;
    wr_val     = cur_data_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          cur_slot_d = head[35:33];
          cur_data_d = head[32:1];
          cur_en_d   = head[0];
          if (head[35:33] >= 3'd6) state_d = SINGLE;
`ifdef CHEAT_PGM_ATOMIC_EN
          else if ((mask_shadow & head_bit) != 6'd0) state_d = MASK_OFF;
`endif
          else state_d = ENTRY;
        end
      end
`ifdef CHEAT_PGM_ATOMIC_EN
      MASK_OFF: begin
        wr_idx = 3'd6;
        wr_val = {26'd0, mask_shadow & ~cur_bit};
        if (commit) begin
          shadow_d = pgm_in[5:0];
          state_d  = ENTRY;
        end
      end
`endif
      ENTRY: begin
        if (commit) begin
`ifdef CHEAT_PGM_ATOMIC_EN
          state_d = cur_en_q ? MASK_ON : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef CHEAT_PGM_ATOMIC_EN
      MASK_ON: begin
        wr_idx = 3'd6;
        wr_val = {26'd0, mask_shadow | cur_bit};
        if (commit) begin
          shadow_d = pgm_in[5:0];
          state_d  = IDLE;
        end
      end
`endif
      SINGLE: begin
        if (commit) begin
          if (cur_slot_q == 3'd6) shadow_d = pgm_in[5:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // pgm_we rises only in an open window and holds its payload until commit
    we_d  = pgm_we;
    idx_d = pgm_idx;
    in_d  = pgm_in;
    if (state_q != IDLE) begin
      if (pgm_we) begin
        if (commit) we_d = 1'b0;
      end else if (win_open) begin
        we_d  = 1'b1;
        idx_d = wr_idx;
        in_d  = wr_val;
      end
    end

    busy_d  = (count_d != '0) || (state_d != IDLE);
    ready_d = (count_d != CW'(FIFO_DEPTH));
  end

  // State, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      cur_slot_q  <= 3'd0;
      cur_data_q  <= 32'd0;
      cur_en_q    <= 1'b0;
      pgm_we      <= 1'b0;
      pgm_idx     <= 3'd0;
      pgm_in      <= 32'd0;
      mask_shadow <= 6'd0;
      busy        <= 1'b0;
      mcu_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q     <= count_d;
      cur_slot_q  <= cur_slot_d;
      cur_data_q  <= cur_data_d;
      cur_en_q    <= cur_en_d;
      pgm_we      <= we_d;
      pgm_idx     <= idx_d;
      pgm_in      <= in_d;
      mask_shadow <= shadow_d;
      busy        <= busy_d;
      mcu_ready   <= ready_d;
    end
  end

endmodule

// File: tb/tb_cheat_pgm_ctrl.sv
// Directed testbench for cheat_pgm_ctrl. Expectations follow the build
// option CHEAT_PGM_ATOMIC_EN when it is defined.
module tb_cheat_pgm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SNES_cycle_start = 1'b0;
  logic        pgm_blocked = 1'b0;
  logic        mcu_valid = 1'b0;
  logic        mcu_ready;
  logic [2:0]  mcu_slot = 3'd0;
  logic [31:0] mcu_data = 32'd0;
  logic        mcu_en = 1'b0;
  logic [2:0]  pgm_idx;
  logic        pgm_we;
  logic [31:0] pgm_in;
  logic [5:0]  mask_shadow;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          snes_en = 1'b0;
  int unsigned ph = 0;
  logic [34:0] cmt_q [$];

  cheat_pgm_ctrl #(.FIFO_DEPTH(4), .GUARD(3), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .SNES_cycle_start(SNES_cycle_start),
    .pgm_blocked(pgm_blocked), .mcu_valid(mcu_valid), .mcu_ready(mcu_ready),
    .mcu_slot(mcu_slot), .mcu_data(mcu_data), .mcu_en(mcu_en),
    .pgm_idx(pgm_idx), .pgm_we(pgm_we), .pgm_in(pgm_in),
    .mask_shadow(mask_shadow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Commit log: a write lands at the next rising edge when we & ~blocked
  always @(negedge clk) begin
    if (rst_n && pgm_we && !pgm_blocked) cmt_q.push_back({pgm_idx, pgm_in});
  end

  // Advance one clock; inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
    if (snes_en) begin
      if (ph >= 11) begin
        ph = 0;
        SNES_cycle_start = 1'b1;
      end else begin
        ph++;
        SNES_cycle_start = 1'b0;
      end
    end else begin
      SNES_cycle_start = 1'b0;
    end
  endtask

  task automatic push(input logic [2:0] slot, input logic [31:0] data, input logic en);
    int unsigned k;
    k = 0;
    while (!mcu_ready && k < 50) begin
      tick();
      k++;
    end
    mcu_valid = 1'b1;
    mcu_slot  = slot;
    mcu_data  = data;
    mcu_en    = en;
    tick();
    mcu_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle: busy=%b after %0d clks, need 0", name, busy, k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++; if (pgm_we !== 1'b0)      begin n_bad++; $display("FAIL reset pgm_we: got %b need 0", pgm_we); end
    n_cmp++; if (pgm_idx !== 3'd0)     begin n_bad++; $display("FAIL reset pgm_idx: got %0d need 0", pgm_idx); end
    n_cmp++; if (pgm_in !== 32'd0)     begin n_bad++; $display("FAIL reset pgm_in: got %h need 0", pgm_in); end
    n_cmp++; if (mask_shadow !== 6'd0) begin n_bad++; $display("FAIL reset mask_shadow: got %h need 00", mask_shadow); end
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset busy: got %b need 0", busy); end
    n_cmp++; if (mcu_ready !== 1'b1)   begin n_bad++; $display("FAIL reset mcu_ready: got %b need 1", mcu_ready); end
  endtask

  task automatic test_entry_enable();
    logic [34:0] exp [$];
    logic [34:0] got;
    logic [5:0]  exp_sh;
    snes_en = 1'b1;
    cmt_q.delete();
    push(3'd2, 32'h00FFEA5C, 1'b1);
    wait_idle("entry_en", 300);
    exp.push_back({3'd2, 32'h00FFEA5C});
`ifdef CHEAT_PGM_ATOMIC_EN
    exp.push_back({3'd6, 32'h00000004});
    exp_sh = 6'h04;
`else
    exp_sh = 6'h00;
`endif
    n_cmp++;
    if (cmt_q.size() != exp.size()) begin
      n_bad++; $display("FAIL entry_en count: got %0d need %0d", cmt_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < cmt_q.size()) ? cmt_q[i] : 'x;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++; $display("FAIL entry_en commit%0d: got %h need %h", i, got, exp[i]);
      end
    end
    n_cmp++;
    if (mask_shadow !== exp_sh) begin
      n_bad++; $display("FAIL entry_en shadow: got %h need %h", mask_shadow, exp_sh);
    end
  endtask

  task automatic test_single_mask();
    logic [34:0] got;
    cmt_q.delete();
    push(3'd6, 32'h00000004, 1'b0);
    push(3'd7, 32'h000000A5, 1'b0);
    wait_idle("single", 300);
    n_cmp++;
    if (cmt_q.size() != 2) begin
      n_bad++; $display("FAIL single count: got %0d need 2", cmt_q.size());
    end
    got = (cmt_q.size() > 0) ? cmt_q[0] : 'x;
    n_cmp++;
    if (got !== {3'd6, 32'h00000004}) begin
      n_bad++; $display("FAIL single slot6: got %h need %h", got, {3'd6, 32'h00000004});
    end
    got = (cmt_q.size() > 1) ? cmt_q[1] : 'x;
    n_cmp++;
    if (got !== {3'd7, 32'h000000A5}) begin
      n_bad++; $display("FAIL single slot7: got %h need %h", got, {3'd7, 32'h000000A5});
    end
    n_cmp++;
    if (mask_shadow !== 6'h04) begin
      n_bad++; $display("FAIL single shadow: got %h need 04", mask_shadow);
    end
  endtask

  task automatic test_entry_disable();
    logic [34:0] exp [$];
    logic [34:0] got;
    logic [5:0]  exp_sh;
    cmt_q.delete();
    push(3'd2, 32'h12345678, 1'b0);
    wait_idle("entry_dis", 300);
`ifdef CHEAT_PGM_ATOMIC_EN
    exp.push_back({3'd6, 32'h00000000});
    exp_sh = 6'h00;
`else
    exp_sh = 6'h04;
`endif
    exp.push_back({3'd2, 32'h12345678});
    n_cmp++;
    if (cmt_q.size() != exp.size()) begin
      n_bad++; $display("FAIL entry_dis count: got %0d need %0d", cmt_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < cmt_q.size()) ? cmt_q[i] : 'x;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++; $display("FAIL entry_dis commit%0d: got %h need %h", i, got, exp[i]);
      end
    end
    n_cmp++;
    if (mask_shadow !== exp_sh) begin
      n_bad++; $display("FAIL entry_dis shadow: got %h need %h", mask_shadow, exp_sh);
    end
  endtask

  task automatic test_blocked();
    int unsigned k;
    logic [34:0] got;
    cmt_q.delete();
    pgm_blocked = 1'b1;
    push(3'd7, 32'hDEADBEEF, 1'b0);
    k = 0;
    while (!pgm_we && k < 60) begin
      tick();
      k++;
    end
    n_cmp++;
    if (pgm_we !== 1'b1) begin
      n_bad++; $display("FAIL blocked raise: pgm_we=%b after %0d clks, need 1", pgm_we, k);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      n_cmp++; if (pgm_we !== 1'b1)       begin n_bad++; $display("FAIL blocked we c%0d: got %b need 1", c, pgm_we); end
      n_cmp++; if (pgm_idx !== 3'd7)      begin n_bad++; $display("FAIL blocked idx c%0d: got %0d need 7", c, pgm_idx); end
      n_cmp++; if (pgm_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL blocked in c%0d: got %h need deadbeef", c, pgm_in); end
    end
    n_cmp++;
    if (cmt_q.size() != 0) begin
      n_bad++; $display("FAIL blocked early commit: got %0d commits need 0", cmt_q.size());
    end
    pgm_blocked = 1'b0;
    tick();
    n_cmp++;
    if (pgm_we !== 1'b0) begin
      n_bad++; $display("FAIL blocked release we: got %b need 0", pgm_we);
    end
    got = (cmt_q.size() > 0) ? cmt_q[0] : 'x;
    n_cmp++;
    if (cmt_q.size() != 1 || got !== {3'd7, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL blocked commit: got %0d commits first %h need 1 of %h", cmt_q.size(), got, {3'd7, 32'hDEADBEEF});
    end
    wait_idle("blocked", 100);
  endtask

  task automatic test_back_to_back();
    logic [5:0]  acc_v;
    logic [34:0] got;
    logic [34:0] exp;
    snes_en = 1'b0;
    repeat (8) tick();
    cmt_q.delete();
    acc_v = 6'd0;
    for (int i = 0; i < 6; i++) begin
      mcu_valid = 1'b1;
      mcu_slot  = 3'd7;
      mcu_data  = 32'h100 + 32'(i);
      mcu_en    = 1'b0;
      acc_v[i]  = mcu_ready;
      tick();
    end
    mcu_valid = 1'b0;
    n_cmp++;
    if (acc_v !== 6'b011111) begin
      n_bad++; $display("FAIL b2b accepts: got %b need 011111", acc_v);
    end
    n_cmp++;
    if (mcu_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b ready: got %b need 0", mcu_ready);
    end
    n_cmp++;
    if (cmt_q.size() != 0) begin
      n_bad++; $display("FAIL b2b no window: got %0d commits need 0", cmt_q.size());
    end
    snes_en = 1'b1;
    wait_idle("b2b", 600);
    n_cmp++;
    if (cmt_q.size() != 5) begin
      n_bad++; $display("FAIL b2b count: got %0d need 5", cmt_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      exp = {3'd7, 32'h100 + 32'(i)};
      got = (i < cmt_q.size()) ? cmt_q[i] : 'x;
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL b2b order%0d: got %h need %h", i, got, exp);
      end
    end
  endtask

  task automatic test_timeout();
    int unsigned k;
    snes_en = 1'b0;
    repeat (2) tick();
    cmt_q.delete();
    SNES_cycle_start = 1'b1;
    @(posedge clk);
    #2;
    SNES_cycle_start = 1'b0;
    k = 0;
    repeat (10) begin tick(); k++; end
    mcu_valid = 1'b1;
    mcu_slot  = 3'd7;
    mcu_data  = 32'h00000077;
    mcu_en    = 1'b0;
    tick();
    k++;
    mcu_valid = 1'b0;
    while (!pgm_we && k < 65545) begin
      tick();
      k++;
    end
    n_cmp++;
    if (!(pgm_we === 1'b1 && k >= 65536 && k <= 65537)) begin
      n_bad++; $display("FAIL timeout rise: pgm_we=%b at clk %0d, need 1 at 65536..65537", pgm_we, k);
    end
    n_cmp++;
    if (pgm_idx !== 3'd7 || pgm_in !== 32'h00000077) begin
      n_bad++; $display("FAIL timeout payload: got idx %0d in %h need idx 7 in 00000077", pgm_idx, pgm_in);
    end
    wait_idle("timeout", 20);
    n_cmp++;
    if (cmt_q.size() != 1) begin
      n_bad++; $display("FAIL timeout count: got %0d need 1", cmt_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int unsigned k;
    snes_en = 1'b1;
    repeat (14) tick();
    cmt_q.delete();
`ifdef CHEAT_PGM_ATOMIC_EN
    pgm_blocked = 1'b0;
    push(3'd3, 32'h00ABCD11, 1'b1);
    k = 0;
    while (cmt_q.size() == 0 && k < 100) begin
      tick();
      k++;
    end
    pgm_blocked = 1'b1;
`else
    pgm_blocked = 1'b1;
    push(3'd6, 32'h0000003F, 1'b0);
`endif
    k = 0;
    while (!pgm_we && k < 100) begin
      tick();
      k++;
    end
    n_cmp++;
    if (pgm_we !== 1'b1 || pgm_idx !== 3'd6) begin
      n_bad++; $display("FAIL rstmid pending: got we %b idx %0d need we 1 idx 6", pgm_we, pgm_idx);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pgm_we !== 1'b0) begin
      n_bad++; $display("FAIL rstmid async we: got %b need 0", pgm_we);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    pgm_blocked = 1'b0;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL rstmid busy: got %b need 0", busy); end
    n_cmp++; if (mask_shadow !== 6'd0) begin n_bad++; $display("FAIL rstmid shadow: got %h need 00", mask_shadow); end
    n_cmp++; if (pgm_we !== 1'b0)      begin n_bad++; $display("FAIL rstmid we: got %b need 0", pgm_we); end
    n_cmp++; if (mcu_ready !== 1'b1)   begin n_bad++; $display("FAIL rstmid ready: got %b need 1", mcu_ready); end
  endtask

  initial begin
    test_reset();
    test_entry_enable();
    test_single_mask();
    test_entry_disable();
    test_blocked();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
